// File: rtl/uart_host.sv
// rtl/uart_host.sv - initiator for the UART register-access protocol (one outstanding request, read timeout)
module uart_host #(
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [2:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_timeout,
  input  logic       tx_busy,
  output logic       tx_enable,
  output logic [7:0] tx_data,
  input  logic       rx_valid,
  input  logic [7:0] rx_data
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CMD_SEND  = 3'd1;
  localparam logic [2:0] S_CMD_WAIT  = 3'd2;
  localparam logic [2:0] S_DATA_SEND = 3'd3;
  localparam logic [2:0] S_DATA_WAIT = 3'd4;
  localparam logic [2:0] S_RSP_WAIT  = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  logic [2:0]    state;
  logic          is_write;
  logic [7:0]    wdata;
  logic          guard;
  logic [CW-1:0] count;

  // Handshake and strobe outputs decoded straight from the state; the enable
  // is gated by busy so a byte is never handed over while uart_tx is occupied.
  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_DONE);
  assign tx_enable = ((state == S_CMD_SEND) || (state == S_DATA_SEND)) && !tx_busy;

  // Transaction sequencer: command byte, optional data byte, then response or timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      is_write    <= 1'b0;
      wdata       <= 8'h00;
      guard       <= 1'b0;
      count       <= '0;
      tx_data     <= 8'h00;
      rsp_rdata   <= 8'h00;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            is_write <= req_write;
            wdata    <= req_wdata;
            tx_data  <= {(req_write ? 3'b010 : 3'b011), 2'b00, req_addr};
            state    <= S_CMD_SEND;
          end
        end
        S_CMD_SEND: begin
          if (!tx_busy) begin
            guard <= 1'b1;
            state <= S_CMD_WAIT;
          end
        end
        S_CMD_WAIT: begin
          // The first wait cycle ignores busy: uart_tx may not have raised it yet.
          if (guard) begin
            guard <= 1'b0;
          end else if (!tx_busy) begin
            if (is_write) begin
              tx_data <= wdata;
              state   <= S_DATA_SEND;
            end else begin
              count <= '0;
              state <= S_RSP_WAIT;
            end
          end
        end
        S_DATA_SEND: begin
          if (!tx_busy) begin
            guard <= 1'b1;
            state <= S_DATA_WAIT;
          end
        end
        S_DATA_WAIT: begin
          if (guard) begin
            guard <= 1'b0;
          end else if (!tx_busy) begin
            rsp_rdata   <= 8'h00;
            rsp_timeout <= 1'b0;
            state       <= S_DONE;
          end
        end
        S_RSP_WAIT: begin
          // A byte arriving on the terminal count still counts as a response.
          if (rx_valid) begin
            rsp_rdata   <= rx_data;
            rsp_timeout <= 1'b0;
            state       <= S_DONE;
          end else if (count == LAST) begin
            rsp_rdata   <= 8'h00;
            rsp_timeout <= 1'b1;
            state       <= S_DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
